// File: rtl/serial_subtractor16.sv
// serial_subtractor16 -- bit-serial 16-bit unsigned subtractor.
//
// One operand pair is accepted in IDLE, processed LSB first at one bit per
// clock in RUN (16 cycles), and presented in DONE until the consumer takes it.
// There is no overlap between operations: the next operand pair can be
// accepted no earlier than the edge after the result handshake.
//
// Optional feature: define SERIAL_SUB_ADD_MODE_EN to add the 'op' port
// (1 = add, 0 = subtract), sampled at accept. In add mode 'borrow' carries the
// carry-out. Without the macro the block always subtracts. Timing is identical
// in both builds.
//
// Ports:
//   clk        in   clock, all state updates on its rising edge
//   rst_n      in   synchronous active-low reset
//   op         in   (SERIAL_SUB_ADD_MODE_EN only) 1 = add, 0 = subtract
//   in_valid   in   operand pair offered
//   in_ready   out  block accepts operands (IDLE only, registered)
//   a          in   [15:0] minuend, unsigned
//   b          in   [15:0] subtrahend, unsigned
//   out_valid  out  result available (DONE only, registered)
//   out_ready  in   consumer takes result
//   diff       out  [15:0] (a - b) mod 2^16  (or a + b in add mode)
//   borrow     out  1 when a < b (or carry-out in add mode)
module serial_subtractor16 (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic        op,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        borrow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic [15:0] a_sh_r;
  logic [15:0] b_sh_r;
  logic [15:0] res_sh_r;
  logic [3:0]  cnt_r;
  logic        br_r;
  logic        op_r;
  logic        op_s;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [15:0] diff_r;
  logic        borrow_r;

  logic        accept_s;
  logic        last_bit_s;
  logic        bit_d_s;
  logic        bit_br_s;

  // One-bit full subtractor: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_bit(input logic x, input logic y, input logic bin);
    logic d;
    logic bout;
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
    return {bout, d};
  endfunction

  // One-bit full adder: returns {carry_out, sum}.
  function automatic logic [1:0] add_bit(input logic x, input logic y, input logic cin);
    logic s;
    logic cout;
    s    = x ^ y ^ cin;
    cout = (x & y) | ((x ^ y) & cin);
    return {cout, s};
  endfunction

`ifdef SERIAL_SUB_ADD_MODE_EN
  assign op_s = op;
`else
  // Subtract-only build: the mode flop is held at subtract.
  assign op_s = 1'b0;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign borrow    = borrow_r;

  assign last_bit_s = (cnt_r == 4'd15);

  // Bit-slice arithmetic on the current LSBs of the operand shifters.
  always_comb begin
    bit_d_s  = 1'b0;
    bit_br_s = 1'b0;
    if (op_r) begin
      {bit_br_s, bit_d_s} = add_bit(a_sh_r[0], b_sh_r[0], br_r);
    end else begin
      {bit_br_s, bit_d_s} = sub_bit(a_sh_r[0], b_sh_r[0], br_r);
    end
  end

  // Next-state logic; accept is qualified by the registered in_ready.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          state_next_s = RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: operand shifters, bit counter, borrow flop and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_r      <= 16'h0000;
      b_sh_r      <= 16'h0000;
      res_sh_r    <= 16'h0000;
      cnt_r       <= 4'd0;
      br_r        <= 1'b0;
      op_r        <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      diff_r      <= 16'h0000;
      borrow_r    <= 1'b0;
    end else begin
      // Handshake flags follow the state being entered so they are
      // registered yet aligned with the state.
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
      if (accept_s) begin
        a_sh_r   <= a;
        b_sh_r   <= b;
        res_sh_r <= 16'h0000;
        cnt_r    <= 4'd0;
        br_r     <= 1'b0;
        op_r     <= op_s;
      end else if (state_r == RUN) begin
        a_sh_r   <= {1'b0, a_sh_r[15:1]};
        b_sh_r   <= {1'b0, b_sh_r[15:1]};
        res_sh_r <= {bit_d_s, res_sh_r[15:1]};
        br_r     <= bit_br_s;
        cnt_r    <= cnt_r + 4'd1;
        // Outputs only change once the whole word is done, so IDLE and RUN
        // keep showing the last completed result.
        if (last_bit_s) begin
          diff_r   <= {bit_d_s, res_sh_r[15:1]};
          borrow_r <= bit_br_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor16.sv
module tb_serial_subtractor16;

  logic        clk;
  logic        rst_n;
  logic        op;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow;

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .op        (op),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference model: whole-word arithmetic plus a cycle
  // count for the fixed 16-cycle latency.
  bit          m_init  = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_done  = 1'b0;
  bit          m_inrdy = 1'b0;
  int          m_cnt   = 0;
  logic [15:0] m_res   = 16'h0000;
  logic        m_bor   = 1'b0;
  logic [15:0] m_diff  = 16'h0000;
  logic        m_borrow = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init   = 1'b1;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_inrdy  = 1'b0;
      m_cnt    = 0;
      m_diff   = 16'h0000;
      m_borrow = 1'b0;
    end else if (m_done) begin
      if (out_ready) begin
        m_done  = 1'b0;
        m_inrdy = 1'b1;
      end
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == 16) begin
        m_busy   = 1'b0;
        m_done   = 1'b1;
        m_diff   = m_res;
        m_borrow = m_bor;
      end
    end else if (in_valid && m_inrdy) begin
      m_busy  = 1'b1;
      m_cnt   = 0;
      m_inrdy = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      if (op) {m_bor, m_res} = {1'b0, a} + {1'b0, b};
      else begin
        m_res = a - b;
        m_bor = (a < b);
      end
`else
      m_res = a - b;
      m_bor = (a < b);
`endif
    end else begin
      m_inrdy = 1'b1;
    end
    #1;
    if (m_init) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, m_inrdy});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_done});
      if (!m_busy) begin
        check("diff", {16'd0, diff}, {16'd0, m_diff});
        check("borrow", {31'd0, borrow}, {31'd0, m_borrow});
      end
    end
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 40) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  // One full operation; 'noisy' scrambles in_valid/a/b while busy.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic top,
                        input int hold, input bit noisy,
                        output logic [15:0] rd, output logic rb);
    int lat;
    wait_ready();
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    op       = top;
    @(posedge clk);
    lat = 0;
    rd  = 16'h0000;
    rb  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
      if (lat > 40) begin
        check("out_valid_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
      if (noisy) begin
        in_valid = 1'($urandom);
        a        = 16'($urandom);
        b        = 16'($urandom);
        op       = ~top;
      end
    end
    check("latency", lat, 32'd16);
    rd = diff;
    rb = borrow;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_diff", {16'd0, diff}, {16'd0, rd});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [15:0] rd;
  logic        rb;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;
    op        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_diff", {16'd0, diff}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_in_ready", {31'd0, in_ready}, 32'd1);

    run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0, rd, rb);
    check("t1_diff", {16'd0, rd}, 32'h1000);
    check("t1_borrow", {31'd0, rb}, 32'd0);

    run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0, rd, rb);
    check("t2_diff", {16'd0, rd}, 32'hFFFF);
    check("t2_borrow", {31'd0, rb}, 32'd1);

    run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0, rd, rb);
    check("t3_diff", {16'd0, rd}, 32'h0000);
    check("t3_borrow", {31'd0, rb}, 32'd0);

    run_op(16'h00FF, 16'h0F00, 1'b0, 10, 1'b0, rd, rb);
    check("t4_diff", {16'd0, rd}, 32'hF1FF);
    check("t4_borrow", {31'd0, rb}, 32'd1);

    // Reset while bit 7 is being processed.
    wait_ready();
    in_valid = 1'b1;
    a        = 16'h8000;
    b        = 16'h0001;
    op       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_diff", {16'd0, diff}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0005, 16'h0003, 1'b0, 0, 1'b0, rd, rb);
    check("t5_diff", {16'd0, rd}, 32'h0002);
    check("t5_borrow", {31'd0, rb}, 32'd0);

    run_op(16'hA5A5, 16'h5A5A, 1'b0, 2, 1'b1, rd, rb);
    check("t6_diff", {16'd0, rd}, 32'h4B4B);
    check("t6_borrow", {31'd0, rb}, 32'd0);

`ifdef SERIAL_SUB_ADD_MODE_EN
    run_op(16'hFFFF, 16'h0001, 1'b1, 0, 1'b0, rd, rb);
    check("add_diff", {16'd0, rd}, 32'h0000);
    check("add_carry", {31'd0, rb}, 32'd1);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, rd, rb);
    check("sub_diff", {16'd0, rd}, 32'hFFFE);
    check("sub_borrow", {31'd0, rb}, 32'd0);
`endif

    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
